// File: rtl/sram_burst_controller_pkg.sv
// Shared types and default sizing for the burst SRAM bridge.
// Modules recompute derived sizes from their own parameters with cnt_width().
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_DQ_W       = 16;
    localparam int DEF_SRAM_AW    = 18;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_RD_WORDS   = 2;
    localparam int DEF_BASE_ADDR  = 1024;
    localparam int DEF_ACCESS_CYC = 1;

    localparam int HALVES   = DEF_WORD_W / DEF_DQ_W;
    localparam int WR_BEATS = HALVES;
    localparam int RD_BEATS = DEF_RD_WORDS * HALVES;

    localparam int BEAT_W = cnt_width((WR_BEATS > RD_BEATS) ? WR_BEATS : RD_BEATS);
    localparam int CYC_W  = cnt_width(DEF_ACCESS_CYC);

endpackage

// File: rtl/sram_burst_controller_if.sv
// CPU-side request/response bundle of the SRAM burst bridge.
interface sram_burst_controller_if
    import sram_ctrl_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int RD_WORDS = DEF_RD_WORDS
) ();

    logic                         wr_en;
    logic                         rd_en;
    logic [31:0]                  address;
    logic [WORD_W-1:0]            writeData;
    logic [RD_WORDS*WORD_W-1:0]   readData;
    logic                         ready;

    modport master (
        output wr_en, rd_en, address, writeData,
        input  readData, ready
    );

    modport slave (
        input  wr_en, rd_en, address, writeData,
        output readData, ready
    );

endinterface

// File: rtl/sram_beat_counter.sv
// Nested cycle-within-beat / beat-within-burst counter shared by reads and writes.
// limit_i is the number of beats in the burst; start_i holds both counters at zero.
module sram_beat_counter
    import sram_ctrl_pkg::*;
#(
    parameter int ACCESS_CYC = DEF_ACCESS_CYC,
    parameter int BEAT_W     = sram_ctrl_pkg::BEAT_W,
    parameter int CYC_W      = sram_ctrl_pkg::CYC_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start_i,
    input  logic              run_i,
    input  logic [BEAT_W:0]   limit_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              beat_last_cycle_o,
    output logic              burst_done_o
);

    logic [CYC_W-1:0]  cyc_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W:0]   last_beat;

    assign last_beat         = limit_i - (BEAT_W+1)'(1);
    assign beat_last_cycle_o = run_i && (cyc_q == CYC_W'(ACCESS_CYC - 1));
    assign burst_done_o      = beat_last_cycle_o && ({1'b0, beat_q} == last_beat);
    assign beat_o            = beat_q;

    always_ff @(posedge clk) begin
        if (srst || start_i) begin
            cyc_q  <= '0;
            beat_q <= '0;
        end else if (run_i) begin
            if (beat_last_cycle_o) begin
                cyc_q  <= '0;
                beat_q <= burst_done_o ? '0 : beat_q + BEAT_W'(1);
            end else begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_burst_controller.sv
// Bridges the MEM stage to an async SRAM: latched single-word writes and
// aligned multi-word read bursts, split into DQ_W-wide beats of ACCESS_CYC cycles.
module sram_burst_controller
    import sram_ctrl_pkg::*;
#(
    parameter int DQ_W       = DEF_DQ_W,
    parameter int SRAM_AW    = DEF_SRAM_AW,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int RD_WORDS   = DEF_RD_WORDS,
    parameter int BASE_ADDR  = DEF_BASE_ADDR,
    parameter int ACCESS_CYC = DEF_ACCESS_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_burst_controller_if.slave bus,
    inout  wire  [DQ_W-1:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0]     SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int HALVES_N    = WORD_W / DQ_W;
    localparam int WR_BEATS_N  = HALVES_N;
    localparam int RD_BEATS_N  = RD_WORDS * HALVES_N;
    localparam int MAX_BEATS_N = (WR_BEATS_N > RD_BEATS_N) ? WR_BEATS_N : RD_BEATS_N;
    localparam int BEAT_W_N    = cnt_width(MAX_BEATS_N);
    localparam int CYC_W_N     = cnt_width(ACCESS_CYC);
    localparam int BYTE_SH     = $clog2(WORD_W / 8);

    state_e              state_q;
    logic [SRAM_AW-1:0]  addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                we_n_q;
    logic                oe_n_q;
    logic                ce_n_q;
    logic                dq_oe_q;
    logic [DQ_W-1:0]     rd_beat_q [RD_BEATS_N];

    logic [31:0]         word_idx;
    logic [SRAM_AW-1:0]  wr_base;
    logic [SRAM_AW-1:0]  rd_base;
    logic [BEAT_W_N:0]   beat_limit;
    logic [BEAT_W_N-1:0] beat;
    logic                beat_last;
    logic                burst_done;

    // Reads are aligned to an RD_WORDS boundary so a burst never straddles lines.
    assign word_idx = (bus.address - 32'(BASE_ADDR)) >> BYTE_SH;
    assign wr_base  = SRAM_AW'(word_idx * 32'(HALVES_N));
    assign rd_base  = SRAM_AW'((word_idx & ~32'(RD_WORDS - 1)) * 32'(HALVES_N));

    assign beat_limit = (state_q == WRITE) ? (BEAT_W_N+1)'(WR_BEATS_N)
                                           : (BEAT_W_N+1)'(RD_BEATS_N);

    sram_beat_counter #(
        .ACCESS_CYC (ACCESS_CYC),
        .BEAT_W     (BEAT_W_N),
        .CYC_W      (CYC_W_N)
    ) u_beat_counter (
        .clk               (clk),
        .srst              (rst),
        .start_i           (state_q == IDLE),
        .run_i             ((state_q == WRITE) || (state_q == READ)),
        .limit_i           (beat_limit),
        .beat_o            (beat),
        .beat_last_cycle_o (beat_last),
        .burst_done_o      (burst_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.wr_en) begin
                        state_q <= WRITE;
                        addr_q  <= wr_base;
                        wdata_q <= bus.writeData;
                        we_n_q  <= 1'b0;
                        ce_n_q  <= 1'b0;
                        dq_oe_q <= 1'b1;
                    end else if (bus.rd_en) begin
                        state_q <= READ;
                        addr_q  <= rd_base;
                        oe_n_q  <= 1'b0;
                        ce_n_q  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (burst_done) begin
                        state_q <= DONE;
                        we_n_q  <= 1'b1;
                        ce_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end else if (beat_last) begin
                        addr_q  <= addr_q + SRAM_AW'(1);
                        wdata_q <= wdata_q >> DQ_W;
                    end
                end
                READ: begin
                    if (burst_done) begin
                        state_q <= DONE;
                        oe_n_q  <= 1'b1;
                        ce_n_q  <= 1'b1;
                    end else if (beat_last) begin
                        addr_q <= addr_q + SRAM_AW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Sample on the last cycle of each beat, after the SRAM has had the full access window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_BEATS_N; i++) begin
                rd_beat_q[i] <= '0;
            end
        end else if ((state_q == READ) && beat_last) begin
            for (int i = 0; i < RD_BEATS_N; i++) begin
                if (beat == BEAT_W_N'(i)) begin
                    rd_beat_q[i] <= SRAM_DQ;
                end
            end
        end
    end

    for (genvar gi = 0; gi < RD_BEATS_N; gi++) begin : g_rd_beat
        assign bus.readData[gi*DQ_W +: DQ_W] = rd_beat_q[gi];
    end

    assign bus.ready = (state_q == DONE) ||
                       ((state_q == IDLE) && !(bus.wr_en || bus.rd_en));

    assign SRAM_DQ   = dq_oe_q ? wdata_q[DQ_W-1:0] : {DQ_W{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_burst_controller.sv
// Scoreboard bench: word-level reference memory predicts each operation's beats,
// latency and read burst; a monitor compares them against the SRAM pins and ready.
module tb_sram_burst_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_burst_controller_if #(.WORD_W(32), .RD_WORDS(2)) bus ();
    sram_burst_controller_if #(.WORD_W(32), .RD_WORDS(2)) bus2 ();

    wire  [15:0] dq;
    logic [17:0] addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    wire  [15:0] dq2;
    logic [17:0] addr2;
    logic        ub2, lb2, we2, ce2, oe2;

    sram_burst_controller u_dut (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    sram_burst_controller #(.ACCESS_CYC(3)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .SRAM_DQ(dq2), .SRAM_ADDR(addr2),
        .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_WE_N(we2),
        .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 40503 + 4660);
    endfunction

    // SRAM device models (write on a clock with WE_N low, combinational read)
    logic [15:0] dev_mem  [256];
    logic [15:0] dev2_mem [256];
    int          phase2 = 0;
    logic [17:0] last_addr2 = '0;
    logic        last_ce2 = 1'b1;

    assign dq  = (!ce_n && !oe_n && we_n) ? dev_mem[8'(addr)] : 16'hzzzz;
    // Second device only returns the right data on the 3rd cycle of each beat.
    assign dq2 = (!ce2 && !oe2 && we2)
               ? ((phase2 == 2) ? dev2_mem[8'(addr2)] : ~dev2_mem[8'(addr2)]) : 16'hzzzz;

    initial begin
        for (int i = 0; i < 256; i++) dev_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!ce_n && !we_n) dev_mem[8'(addr)] = dq;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) dev2_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!ce2 && !last_ce2 && addr2 == last_addr2) phase2++;
            else phase2 = 0;
            last_addr2 = addr2;
            last_ce2   = ce2;
        end
    end

    // Reference model: halfword memory image plus last read burst
    typedef struct {
        bit                is_wr;
        int                nbeats;
        logic [3:0][17:0]  a;
        logic [3:0][15:0]  d;
        logic [63:0]       rdata;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [256];
    logic [63:0] last_rd = '0;

    function automatic exp_t model(input bit is_wr, input logic [31:0] address,
                                   input logic [31:0] data);
        exp_t        e;
        logic [31:0] w;
        logic [31:0] base;
        w        = (address - 32'd1024) / 32'd4;
        e.is_wr  = is_wr;
        e.a      = '0;
        e.d      = '0;
        if (is_wr) begin
            e.nbeats = 2;
            for (int k = 0; k < 2; k++) begin
                e.a[k] = 18'(w * 2 + 32'(k));
                e.d[k] = (k == 0) ? data[15:0] : data[31:16];
                ref_mem[8'(e.a[k])] = e.d[k];
            end
            e.rdata = last_rd;
        end else begin
            e.nbeats = 4;
            base     = (w - (w % 2)) * 2;
            e.rdata  = '0;
            for (int i = 0; i < 4; i++) begin
                e.a[i]  = 18'(base + 32'(i));
                e.rdata = e.rdata | (64'(ref_mem[8'(e.a[i])]) << (16 * i));
            end
            last_rd = e.rdata;
        end
        return e;
    endfunction

    // Monitor: collects SRAM activity, scores each operation at its ready pulse
    int          mcnt = 0;
    logic [17:0] oa[$];
    logic [15:0] od[$];
    logic        ow[$];
    logic        oo[$];
    exp_t        me;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mcnt = 0;
                oa.delete(); od.delete(); ow.delete(); oo.delete();
            end else begin
                check("we_oe_overlap", 64'(!we_n && !oe_n), 64'd0);
                if (!ce_n) begin
                    oa.push_back(addr); od.push_back(dq);
                    ow.push_back(we_n); oo.push_back(oe_n);
                end
                if (!bus.ready) begin
                    mcnt++;
                end else if (mcnt > 0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_op", 64'd1, 64'd0);
                    end else begin
                        me = sb.pop_front();
                        check("latency", 64'(mcnt), 64'(me.nbeats + 1));
                        check("beat_count", 64'(oa.size()), 64'(me.nbeats));
                        for (int i = 0; i < me.nbeats && i < oa.size(); i++) begin
                            check("beat_addr", 64'(oa[i]), 64'(me.a[i]));
                            check("beat_strobes", 64'({ow[i], oo[i]}),
                                  me.is_wr ? 64'd1 : 64'd2);
                            if (me.is_wr) check("beat_wdata", 64'(od[i]), 64'(me.d[i]));
                        end
                        check("readData", bus.readData, me.rdata);
                        check("ub_lb", 64'({ub_n, lb_n}), 64'd0);
                    end
                    mcnt = 0;
                    oa.delete(); od.delete(); ow.delete(); oo.delete();
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.ready && k < 50);
        if (!bus.ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input bit wr, input bit rd, input logic [31:0] address,
                         input logic [31:0] data, input bit hold);
        int nops = hold ? 2 : 1;
        for (int n = 0; n < nops; n++) sb.push_back(model(wr, address, data));
        $display("op: wr=%0b rd=%0b addr=%0d data=%h hold=%0b", wr, rd, address, data, hold);
        @(posedge clk); #1;
        bus.wr_en = wr; bus.rd_en = rd; bus.address = address; bus.writeData = data;
        @(posedge clk); #1;
        for (int n = 0; n < nops; n++) begin
            if (n == nops - 1) begin
                bus.wr_en = 1'b0; bus.rd_en = 1'b0;
                bus.address = $urandom; bus.writeData = $urandom;
            end
            wait_ready();
            if (n < nops - 1) begin
                @(posedge clk); @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int cyc;
        bit wr, rd, hold;
        logic [31:0] a;
        logic [63:0] exp2;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        bus.wr_en = 0;  bus.rd_en = 0;  bus.address = 0;  bus.writeData = 0;
        bus2.wr_en = 0; bus2.rd_en = 0; bus2.address = 0; bus2.writeData = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_strobes", 64'({we_n, oe_n, ce_n, ub_n, lb_n}), 64'b11100);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_readData", bus.readData, 64'd0);

        do_op(1, 0, 32'd1032, 32'hDEADBEEF, 0);
        do_op(1, 0, 32'd1036, 32'h12345678, 0);
        do_op(0, 1, 32'd1036, 32'h0, 0);
        do_op(1, 1, 32'd1040, 32'hCAFEF00D, 0);
        do_op(0, 1, 32'd1040, 32'h0, 0);

        // Reset one cycle into a write: second beat must never reach the SRAM
        @(posedge clk); #1;
        bus.wr_en = 1; bus.address = 32'd1032; bus.writeData = 32'h11112222;
        @(posedge clk); #1;
        rst = 1'b1; bus.wr_en = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        $display("op: reset during write");
        check("abort_strobes", 64'({we_n, oe_n, ce_n}), 64'b111);
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_readData", bus.readData, 64'd0);
        check("abort_addr", 64'(addr), 64'd0);
        check("abort_mem5", 64'(dev_mem[5]), 64'(ref_mem[5]));
        check("abort_mem4", 64'(dev_mem[4]), 64'h2222);
        ref_mem[4] = 16'h2222;
        last_rd    = '0;
        do_op(0, 1, 32'd1032, 32'h0, 0);

        for (int t = 0; t < 60; t++) begin
            wr   = 1'($urandom_range(0, 1));
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = ($urandom_range(0, 3) == 0);
            a    = 32'd1024 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            do_op(wr, rd, a, $urandom, hold);
        end

        // Slow part: 3 cycles per beat, read at the base address
        @(posedge clk); #1;
        bus2.rd_en = 1; bus2.address = 32'd1024;
        @(posedge clk); #1;
        bus2.rd_en = 0; bus2.address = $urandom;
        cyc = 1;
        forever begin
            @(negedge clk);
            if (bus2.ready || cyc > 40) break;
            check("slow_addr", 64'(addr2), 64'((cyc - 1) / 3));
            check("slow_strobes", 64'({we2, oe2, ce2, ub2, lb2}), 64'b10000);
            cyc++;
        end
        exp2 = '0;
        for (int i = 0; i < 4; i++) exp2 = exp2 | (64'(init_val(i)) << (16 * i));
        $display("op: slow read addr=1024 ready_cycle=%0d data=%h", cyc, bus2.readData);
        check("slow_latency", 64'(cyc), 64'd13);
        check("slow_readData", bus2.readData, exp2);

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
